// File: rtl/cnn_fixed_pkg.sv
// Shared fixed-point types and helpers for the CNN post-processing stages.
package cnn_fixed_pkg;

  localparam int N_DEF = 24;  // total word width, signed two's complement
  localparam int Q_DEF = 13;  // fractional bits (binary point position only)

  typedef logic signed [N_DEF-1:0] fx_t;

  // ReLU: negative values clamp to zero, everything else passes unchanged.
  function automatic fx_t relu_fx(input fx_t x);
    return x[N_DEF-1] ? '0 : x;
  endfunction

  // Signed maximum of two fixed-point words.
  function automatic fx_t max_fx(input fx_t a, input fx_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Holds one horizontal-pair maximum per pooling column while the second
// row of a 2x2 window streams in. Contents are never reset; every entry is
// written on an even row before the following odd row reads it.
module pool_line_buffer
  import cnn_fixed_pkg::*;
#(
  parameter int DEPTH = 20,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  fx_t           wdata,
  output fx_t           rdata
);

  fx_t mem [DEPTH];

  // Single synchronous write port.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/relu_maxpool2x2_stream.sv
// ReLU followed by 2x2/stride-2 max-pool over a raster-order feature map,
// valid/ready on both sides, one registered output word.
module relu_maxpool2x2_stream
  import cnn_fixed_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF,
  parameter int H = 8,
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         global_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last
);

  localparam int CW    = $clog2(W);
  localparam int RW    = $clog2(H);
  localparam int DEPTH = W / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] COL_LAST     = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(H - 1);
  // Last column/row that belongs to a complete 2x2 window; beyond these an
  // odd-sized map's trailing pixels are accepted and dropped.
  localparam logic [CW-1:0] COL_POOL_END = CW'(2 * (W / 2) - 1);
  localparam logic [RW-1:0] ROW_POOL_END = RW'(2 * (H / 2) - 1);

  // Q only documents where the binary point sits; max and ReLU ignore it.
  logic unused_q;
  assign unused_q = ^Q;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          col_in;
  logic          row_in;
  logic          lb_we;
  logic [AW-1:0] lb_addr;
  fx_t           r;
  fx_t           pair_q;
  fx_t           pair_max;
  fx_t           lb_rdata;
  fx_t           win_max;
  fx_t           out_q;

  assign in_ready = global_rst & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  assign col_in   = (col <= COL_POOL_END);
  assign row_in   = (row <= ROW_POOL_END);
  assign lb_addr  = AW'(col >> 1);

  assign r        = relu_fx(fx_t'(in_data));
  assign pair_max = max_fx(pair_q, r);
  assign win_max  = max_fx(lb_rdata, pair_max);

  // Even rows park the horizontal pair maximum for the row below.
  assign lb_we    = accept & row_in & col_in & col[0] & ~row[0];

  assign out_data = N'(out_q);

  pool_line_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (lb_we),
    .addr  (lb_addr),
    .wdata (pair_max),
    .rdata (lb_rdata)
  );

  // Raster counters, pair register and output register with handshake.
  always_ff @(posedge clk) begin
    if (!global_rst) begin
      col       <= '0;
      row       <= '0;
      pair_q    <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (row_in && col_in && !col[0]) pair_q <= r;
        // Bottom-right pixel of a window: produce, overriding any clear above.
        if (row_in && col_in && col[0] && row[0]) begin
          out_q     <= win_max;
          out_valid <= 1'b1;
          out_last  <= (row == ROW_POOL_END) && (col == COL_POOL_END);
        end
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool2x2_stream.sv
// Bench for relu_maxpool2x2_stream: a 4x4 instance for the main scenarios
// and a 5x5 instance for odd-size trimming, checked against a pooling model.
module tb_relu_maxpool2x2_stream;

  typedef struct {
    int d;
    bit l;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv4, ir4, ov4, ol4, ordy4;
  logic [23:0] id4, od4;
  logic        iv5, ir5, ov5, ol5, ordy5;
  logic [23:0] id5, od5;

  int   n_vec = 0;
  int   n_err = 0;
  int   in_q[$];
  exp_t exp_q[$];

  relu_maxpool2x2_stream #(.N(24), .Q(13), .H(4), .W(4)) u_dut4 (
    .clk(clk), .global_rst(rst_n),
    .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .out_valid(ov4), .out_ready(ordy4), .out_data(od4), .out_last(ol4)
  );

  relu_maxpool2x2_stream #(.N(24), .Q(13), .H(5), .W(5)) u_dut5 (
    .clk(clk), .global_rst(rst_n),
    .in_valid(iv5), .in_ready(ir5), .in_data(id5),
    .out_valid(ov5), .out_ready(ordy5), .out_data(od5), .out_last(ol5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pool model: each output is the largest of the four window pixels after
  // ReLU, i.e. max(0, raw window max). Trailing odd row/column are ignored.
  task automatic model(input int h, input int w, input int px[$]);
    exp_t e;
    for (int i = 0; i < h / 2; i++) begin
      for (int j = 0; j < w / 2; j++) begin
        int m;
        m = 0;
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++)
            if (px[(2 * i + dy) * w + 2 * j + dx] > m) m = px[(2 * i + dy) * w + 2 * j + dx];
        e.d = m;
        e.l = (i == h / 2 - 1) && (j == w / 2 - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // kind 0: ramp 1..16 in Q13, kind 1: negative ramp, kind 2: random words.
  task automatic frame4(input int kind, input bit expect_out);
    int px[$];
    for (int k = 0; k < 16; k++) begin
      case (kind)
        0:       px.push_back((k + 1) * 8192);
        1:       px.push_back(-(k + 1) * 8192);
        default: px.push_back(int'($urandom_range(16777215)) - 8388608);
      endcase
    end
    foreach (px[k]) in_q.push_back(px[k]);
    if (expect_out) model(4, 4, px);
  endtask

  task automatic run4(input int pv, input int pr, input bit stall_first, input int budget);
    int cyc;
    int stall_left;
    bit stalled_once;
    bit v, rd;
    int t;
    logic [31:0] e;
    cyc = 0;
    stall_left = 0;
    stalled_once = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      v = (in_q.size() > 0) && ($urandom_range(99) < pv);
      t = v ? in_q[0] : int'($urandom);
      iv4 = v;
      id4 = t[23:0];
      if (stall_first && ov4 && !stalled_once) begin
        stalled_once = 1;
        stall_left = 10;
      end
      if (stall_left > 0) begin
        rd = 0;
        stall_left--;
      end else begin
        rd = ($urandom_range(99) < pr);
      end
      ordy4 = rd;
      #1;
      if (ov4) begin
        if (exp_q.size() == 0) begin
          chk("extra_output", 32'd1, 32'd0);
        end else begin
          e = 32'(exp_q[0].d);
          chk("out_data", {8'd0, od4}, {8'd0, e[23:0]});
          if (rd) begin
            chk("out_last", {31'd0, ol4}, {31'd0, exp_q[0].l});
            void'(exp_q.pop_front());
          end else begin
            chk("stall_in_ready", {31'd0, ir4}, 32'd0);
          end
        end
      end
      if (v && ir4) void'(in_q.pop_front());
    end
    if (in_q.size() > 0 || exp_q.size() > 0) begin
      chk("timeout", 32'd1, 32'd0);
      in_q.delete();
      exp_q.delete();
    end
    @(negedge clk);
    iv4 = 1'b0;
    ordy4 = 1'b1;
  endtask

  initial begin
    int idx;
    int cyc;
    int px5[$];
    logic [31:0] e;

    rst_n = 1'b0;
    iv4 = 1'b0; id4 = '0; ordy4 = 1'b1;
    iv5 = 1'b0; id5 = '0; ordy5 = 1'b1;
    repeat (2) @(negedge clk);
    iv4 = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, ov4}, 32'd0);
    chk("rst_out_data", {8'd0, od4}, 32'd0);
    chk("rst_out_last", {31'd0, ol4}, 32'd0);
    chk("rst_in_ready", {31'd0, ir4}, 32'd0);
    chk("rst_in_ready5", {31'd0, ir5}, 32'd0);
    @(negedge clk);
    iv4 = 1'b0;
    rst_n = 1'b1;

    // Scaled ramp, free-flowing.
    frame4(0, 1);
    run4(100, 100, 0, 200);

    // All negative inputs pool to zero.
    frame4(1, 1);
    run4(100, 100, 0, 200);

    // Ten-cycle consumer stall on the first output of the ramp.
    frame4(0, 1);
    run4(100, 100, 1, 200);

    // Two back-to-back random frames with random handshakes.
    frame4(2, 1);
    frame4(2, 1);
    run4(60, 60, 0, 1000);

    // Partial frame, one-cycle reset, then a full clean frame.
    for (int k = 0; k < 6; k++) in_q.push_back(int'($urandom_range(16777215)) - 8388608);
    run4(100, 100, 0, 100);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, ir4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_valid", {31'd0, ov4}, 32'd0);
    frame4(2, 1);
    run4(80, 80, 0, 400);

    // 5x5 ramp: trailing row and column are dropped.
    for (int k = 0; k < 25; k++) px5.push_back(k);
    model(5, 5, px5);
    idx = 0;
    cyc = 0;
    while ((idx < 25 || exp_q.size() > 0) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      iv5 = (idx < 25);
      id5 = 24'(idx);
      #1;
      if (ov5) begin
        if (exp_q.size() == 0) begin
          chk("extra_output5", 32'd1, 32'd0);
        end else begin
          e = 32'(exp_q[0].d);
          chk("out_data5", {8'd0, od5}, {8'd0, e[23:0]});
          chk("out_last5", {31'd0, ol5}, {31'd0, exp_q[0].l});
          void'(exp_q.pop_front());
        end
      end
      if (iv5 && ir5) idx++;
    end
    if (idx < 25 || exp_q.size() > 0) chk("timeout5", 32'd1, 32'd0);
    @(negedge clk);
    iv5 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("idle5_valid", {31'd0, ov5}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
